pll_phase_step_ctrl: RTL
========================

// Module: pll_phase_step_ctrl
// PURPOSE
//  Sequences the dynamic-phase-shift (DPS) port of the resetalign PLL (125 MHz in, 125 MHz out, Arria V DPS).
//  Accepts signed step commands for one PLL counter and issues one phase_en pulse per step.
//  Waits for each phase_done handshake and keeps a running phase position.
//  Sits between the reset-alignment logic/slow control and the PLL DPS pins, clocked by the PLL scanclk.
// PARAMETERS
//  STEP_W        8    width of signed cmd_steps
//  POS_W         16   width of signed accumulated position (wraps modulo 2^POS_W)
//  EN_CYCLES     2    scanclk cycles phase_en is held high per step (>=1)
//  GAP_CYCLES    2    idle cycles between consecutive steps (>=0)
//  TIMEOUT       255  max cycles waiting for the phase_done low+high handshake per step
// PORTS
//  scanclk      in   1      clock; all logic synchronous to it
//  rst          in   1      asynchronous, active-high reset
//  cmd_valid    in   1      command request
//  cmd_ready    out  1      block accepts command this cycle
//  cmd_steps    in   STEP_W signed step count; >0 = up, <0 = down, 0 = no-op
//  cmd_cntsel   in   5      PLL counter select for this command
//  clear_pos    in   1      synchronous clear of phase_pos (ignored while busy)
//  pll_locked   in   1      PLL locked (async; synchronised internally, 2 flops)
//  phase_en     out  1      to PLL phase_en
//  updn         out  1      to PLL updn (1 = up)
//  cntsel       out  5      to PLL cntsel
//  phase_done   in   1      from PLL (async; synchronised internally, 2 flops)
//  busy         out  1      command in progress
//  done         out  1      1-cycle pulse at command end (success or error)
//  error        out  1      sticky; set on timeout or lock loss, cleared on next accepted command
//  phase_pos    out  POS_W  signed cumulative steps applied since reset/clear
// BEHAVIOUR
//  Reset: phase_en=0, updn=0, cntsel=0, cmd_ready=0, busy=0, done=0, error=0, phase_pos=0, FSM=IDLE.
//  cmd_ready = (state==IDLE) & locked_s. Accept on cmd_valid&cmd_ready; latch |steps| in STEP_W+1 bits so that -2^(STEP_W-1) is exact.
//  Accept also latches updn=(steps>0) and cntsel, clears error, and sets busy=1 in the same edge.
//  updn/cntsel hold their values after the command completes.
//  States:
//   IDLE      -> SETUP on accept with steps!=0; with steps==0: done pulse next cycle, stay IDLE, busy stays 0.
//   SETUP     1 cycle; cntsel/updn stable before phase_en rises -> PULSE.
//   PULSE     phase_en=1 for EN_CYCLES cycles -> WAIT_LO.
//   WAIT_LO   wait phase_done_s==0 -> WAIT_HI.
//   WAIT_HI   wait phase_done_s==1 -> step complete: phase_pos +/-= 1, remaining -= 1;
//             remaining==0 -> FIN, else GAP.
//   GAP       GAP_CYCLES idle (0 = skip) -> SETUP.
//   FIN       done=1 for 1 cycle, busy=0 -> IDLE.
//  Timeout: counter reset on entering WAIT_LO and counts both WAIT_LO and WAIT_HI.
//   Reaching TIMEOUT -> error=1, FIN. phase_pos is not updated for that step.
//  Lock loss: locked_s==0 in any state other than IDLE/FIN -> phase_en=0 same edge, error=1, FIN.
//   Steps already counted stay in phase_pos.
//  Simultaneous: phase_done_s rising on the same cycle as timeout expiry counts as success.
//   Lock loss takes priority over both.
//  clear_pos with accept in the same cycle: clear applies, command proceeds.
//  phase_pos wraps two's-complement, no saturation. cmd_valid while busy is ignored (cmd_ready=0).
//  Async rst mid-command: phase_en drops immediately; the in-flight PLL step is not tracked.
// TESTING
//  T1 reset, locked=1, cmd_steps=+3, cntsel=0 -> 3 phase_en pulses of 2 cycles, updn=1, phase_pos=3,
//     single done pulse, error=0.
//  T2 cmd_steps=-128 (STEP_W=8) -> 128 pulses, updn=0, phase_pos=-128 (after T1 + clear_pos).
//  T3 cmd_steps=0 -> no phase_en, done pulse 1 cycle after accept, phase_pos unchanged.
//  T4 PLL model never drops phase_done, cmd_steps=+2 -> error=1 after TIMEOUT cycles, phase_pos +0, done pulse.
//  T5 drop pll_locked during step 2 of +5 -> phase_en low, error=1, phase_pos=+1, cmd_ready=0 until relock.
//  T6 phase_pos=32767 (POS_W=16), cmd_steps=+1 -> phase_pos=-32768; cmd_valid held during busy accepted only after done.

Source files
------------

// File: rtl/pll_phase_step_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pll_phase_step_ctrl_if
// Command channel into the PLL phase-step sequencer.
//   cmd_valid  : requester has a step command
//   cmd_ready  : sequencer accepts the command this cycle
//   cmd_steps  : signed step count (>0 up, <0 down, 0 no-op)
//   cmd_cntsel : PLL counter the command applies to
// master = command source, slave = sequencer.
// ---------------------------------------------------------------------------
interface pll_phase_step_ctrl_if #(
  parameter int STEP_W = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic signed [STEP_W-1:0] cmd_steps;
  logic [4:0]               cmd_cntsel;

  modport master (output cmd_valid, output cmd_steps, output cmd_cntsel, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_steps, input cmd_cntsel, output cmd_ready);
endinterface

// File: rtl/pll_phase_step_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pll_phase_step_ctrl
// Drives the dynamic-phase-shift pins of the reset-alignment PLL. A signed
// step command is broken into single phase_en pulses; each pulse waits for
// the PLL's phase_done low/high handshake before the next one is issued, and
// a running signed phase position is kept.
// Ports:
//   scanclk, rst  : PLL scan clock, asynchronous active-high reset
//   cmd           : command channel (slave side)
//   clear_pos     : clears phase_pos while idle
//   pll_locked    : asynchronous lock indication, synchronised here
//   phase_en, updn, cntsel : to the PLL DPS port
//   phase_done    : asynchronous handshake from the PLL, synchronised here
//   busy, done, error, phase_pos : status towards slow control
// ---------------------------------------------------------------------------
module pll_phase_step_ctrl #(
  parameter int STEP_W     = 8,
  parameter int POS_W      = 16,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    scanclk,
  input  logic                    rst,
  pll_phase_step_ctrl_if.slave    cmd,
  input  logic                    clear_pos,
  input  logic                    pll_locked,
  output logic                    phase_en,
  output logic                    updn,
  output logic [4:0]              cntsel,
  input  logic                    phase_done,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic signed [POS_W-1:0] phase_pos
);

  localparam int REM_W = STEP_W + 1;
  localparam int CNT_W = 16;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_GAP,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic               locked_meta_q, locked_meta_d, locked_s_q, locked_s_d;
  logic               pdone_meta_q, pdone_meta_d, pdone_s_q, pdone_s_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   en_cnt_q, en_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               phase_en_q, phase_en_d;
  logic               updn_q, updn_d;
  logic [4:0]         cntsel_q, cntsel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [POS_W-1:0]   pos_q, pos_d;

  logic               ready;
  logic               accept;
  logic               timeout_hit;
  logic [REM_W-1:0]   steps_ext;
  logic [REM_W-1:0]   steps_abs;
  logic               steps_up;

  assign ready  = (state_q == S_IDLE) && locked_s_q;
  assign accept = cmd.cmd_valid && ready;

  // Magnitude is taken one bit wider so the most negative command is exact.
  assign steps_ext = {cmd.cmd_steps[STEP_W-1], cmd.cmd_steps};
  assign steps_abs = steps_ext[REM_W-1] ? (~steps_ext + REM_W'(1)) : steps_ext;
  assign steps_up  = !cmd.cmd_steps[STEP_W-1] && (cmd.cmd_steps != '0);

  // The wait counter spans both handshake phases of one step.
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Next-state and next-output logic for the step sequencer.
  always_comb begin
    locked_meta_d = pll_locked;
    locked_s_d    = locked_meta_q;
    pdone_meta_d  = phase_done;
    pdone_s_d     = pdone_meta_q;
    state_d       = state_q;
    rem_d         = rem_q;
    en_cnt_d      = en_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    to_cnt_d      = to_cnt_q;
    phase_en_d    = phase_en_q;
    updn_d        = updn_q;
    cntsel_d      = cntsel_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    pos_d         = pos_q;

    case (state_q)
      S_IDLE: begin
        if (clear_pos) pos_d = '0;
        if (accept) begin
          error_d  = 1'b0;
          updn_d   = steps_up;
          cntsel_d = cmd.cmd_cntsel;
          rem_d    = steps_abs;
          if (steps_abs == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        phase_en_d = 1'b1;
        en_cnt_d   = '0;
        state_d    = S_PULSE;
      end
      S_PULSE: begin
        if (int'(en_cnt_q) == EN_CYCLES - 1) begin
          phase_en_d = 1'b0;
          to_cnt_d   = '0;
          state_d    = S_WAIT_LO;
        end else begin
          en_cnt_d = en_cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout_hit) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (!pdone_s_q) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A rising handshake on the expiry cycle still counts as a good step.
        if (pdone_s_q) begin
          pos_d = updn_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_SETUP;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_GAP: begin
        if (int'(gap_cnt_q) >= GAP_CYCLES - 1) begin
          state_d = S_SETUP;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lock loss overrides everything in the active states, including a step
    // that would otherwise complete on this cycle.
    if (!locked_s_q && (state_q != S_IDLE) && (state_q != S_FIN)) begin
      phase_en_d = 1'b0;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      pos_d      = pos_q;
      rem_d      = rem_q;
      state_d    = S_FIN;
    end
  end

  // All state, synchronisers and registered outputs.
  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      pdone_meta_q  <= 1'b0;
      pdone_s_q     <= 1'b0;
      rem_q         <= '0;
      en_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      to_cnt_q      <= '0;
      phase_en_q    <= 1'b0;
      updn_q        <= 1'b0;
      cntsel_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      pos_q         <= '0;
    end else begin
      state_q       <= state_d;
      locked_meta_q <= locked_meta_d;
      locked_s_q    <= locked_s_d;
      pdone_meta_q  <= pdone_meta_d;
      pdone_s_q     <= pdone_s_d;
      rem_q         <= rem_d;
      en_cnt_q      <= en_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      to_cnt_q      <= to_cnt_d;
      phase_en_q    <= phase_en_d;
      updn_q        <= updn_d;
      cntsel_q      <= cntsel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      pos_q         <= pos_d;
    end
  end

  assign cmd.cmd_ready = ready;
  assign phase_en      = phase_en_q;
  assign updn          = updn_q;
  assign cntsel        = cntsel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign phase_pos     = pos_q;

endmodule
